// File: rtl/seq_mult_unit.sv
// Shift-and-add multiplier, one multiplier bit per cycle; start/busy/done handshake.
// Latency WIDTH cycles from the accepting edge to done; start is ignored while busy.
// Define SEQ_MULT_SIGNED_EN for two's-complement operands (default: unsigned).
module seq_mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [CW-1:0]      count;
    logic               last_step;
    logic [WIDTH:0]     up_ext;
    logic [WIDTH:0]     mc_ext;
    logic [WIDTH:0]     sum;

    assign last_step = (count == CW'(1));

    // One adder step: upper half of acc plus (optionally) the multiplicand, carry kept.
    always_comb begin
`ifdef SEQ_MULT_SIGNED_EN
        up_ext = {acc[2*WIDTH-1], acc[2*WIDTH-1:WIDTH]};
        mc_ext = {mcand[WIDTH-1], mcand};
`else
        up_ext = {1'b0, acc[2*WIDTH-1:WIDTH]};
        mc_ext = {1'b0, mcand};
`endif
        sum = up_ext;
        if (acc[0]) begin
`ifdef SEQ_MULT_SIGNED_EN
            // The multiplier's sign bit carries weight -2^(WIDTH-1).
            if (last_step)
                sum = up_ext - mc_ext;
            else
                sum = up_ext + mc_ext;
`else
            sum = up_ext + mc_ext;
`endif
        end
        acc_nxt = {sum, acc[WIDTH-1:1]};
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_step)
                    state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mcand   <= '0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= a;
                        acc   <= {{WIDTH{1'b0}}, b};
                        count <= CW'(WIDTH);
                    end
                end
                RUN: begin
                    acc   <= acc_nxt;
                    count <= count - CW'(1);
                    if (last_step)
                        product <= acc_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule
